// File: rtl/ysyx_23060221_axi_rd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060221_axi_rd_rr_arbiter
// Brief    : Two-master (IFU m0 / LSU m1) AXI4 read-channel round-robin arbiter
//            with the grant locked from AR acceptance through the last R beat.
//            Optional R-phase watchdog enabled by defining ARB_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060221_axi_rd_rr_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int IDW            = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ARB_RD_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [AW+IDW+12:0]    m0_ar,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DW+IDW+1:0]     m0_r,
    output logic                  m0_rlast,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [AW+IDW+12:0]    m1_ar,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DW+IDW+1:0]     m1_r,
    output logic                  m1_rlast,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [AW+IDW+12:0]    s_ar,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DW+IDW+1:0]     s_r,
    input  logic                  s_rlast
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t r_state;
    logic   r_grant;        // 0 = m0 (IFU), 1 = m1 (LSU)
    logic   r_last_grant;

    logic                 w_pick;
    logic                 w_in_addr;
    logic                 w_in_data;
    logic                 w_g_arvalid;
    logic [AW+IDW+12:0]   w_g_ar;
    logic                 w_g_rready;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_last_hs;
    logic                 w_tout;
    logic                 w_tout_hs;
    logic [DW+IDW+1:0]    w_err_r;
    logic                 w_rvalid;
    logic                 w_rlast;
    logic [DW+IDW+1:0]    w_r;

    // On a tie the master that was not served last wins.
    assign w_pick = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;

    assign w_in_addr   = (r_state == S_ADDR);
    assign w_in_data   = (r_state == S_DATA);
    assign w_g_arvalid = r_grant ? m1_arvalid : m0_arvalid;
    assign w_g_ar      = r_grant ? m1_ar      : m0_ar;
    assign w_g_rready  = r_grant ? m1_rready  : m0_rready;

    assign s_arvalid = w_in_addr & w_g_arvalid;
    assign s_ar      = w_in_addr ? w_g_ar : '0;
    assign w_ar_hs   = s_arvalid & s_arready;

    assign s_rready  = w_in_data & ~w_tout & w_g_rready;
    assign w_r_hs    = s_rvalid & s_rready;
    assign w_last_hs = w_r_hs & s_rlast;
    assign w_tout_hs = w_tout & w_g_rready;

    assign w_rvalid = w_in_data & (w_tout | s_rvalid);
    assign w_rlast  = w_in_data & (w_tout | s_rlast);
    assign w_r      = !w_in_data ? '0 : (w_tout ? w_err_r : s_r);

    assign m0_arready = w_in_addr & ~r_grant & s_arready;
    assign m1_arready = w_in_addr &  r_grant & s_arready;
    assign m0_rvalid  = ~r_grant & w_rvalid;
    assign m1_rvalid  =  r_grant & w_rvalid;
    assign m0_rlast   = ~r_grant & w_rlast;
    assign m1_rlast   =  r_grant & w_rlast;
    assign m0_r       = r_grant ? '0  : w_r;
    assign m1_r       = r_grant ? w_r : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        r_grant <= w_pick;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // A withdrawn request releases the grant without touching fairness.
                    if (!w_g_arvalid) begin
                        r_state <= S_IDLE;
                    end else if (s_arready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_last_hs || w_tout_hs) begin
                        r_state      <= S_IDLE;
                        r_last_grant <= r_grant;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_RD_TIMEOUT_EN
    localparam logic [9:0] c_timeout_limit = 10'(TIMEOUT_CYCLES);

    logic [9:0]     r_cnt;
    logic [IDW-1:0] r_ar_id;
    logic           r_timeout_err;

    assign w_tout      = w_in_data && (r_cnt == c_timeout_limit);
    assign w_err_r     = {{DW{1'b0}}, r_ar_id, 2'b11};
    assign timeout_err = r_timeout_err;

    // Counter saturates at the limit so the DECERR beat is held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_ar_id       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_cnt   <= '0;
                r_ar_id <= s_ar[IDW+12:13];
            end else if (w_in_data) begin
                if (w_r_hs) begin
                    r_cnt <= '0;
                end else if (!w_tout) begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt + 10'd1 == c_timeout_limit) begin
                        r_timeout_err <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic w_unused;

    assign w_tout   = 1'b0;
    assign w_err_r  = '0;
    assign w_unused = ^{1'b0, 10'(TIMEOUT_CYCLES)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060221_axi_rd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060221_axi_rd_rr_arbiter
// Brief    : Scoreboard bench for the two-master AXI read round-robin arbiter
//            (timeout scenario compiled in when ARB_RD_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060221_axi_rd_rr_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 4;
    localparam int ARW = AW + IDW + 13;
    localparam int RW  = DW + IDW + 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic           m0_arready, m1_arready;
    logic [ARW-1:0] m0_ar = '0, m1_ar = '0;
    logic           m0_rvalid, m1_rvalid;
    logic           m0_rready = 1'b1, m1_rready = 1'b1;
    logic [RW-1:0]  m0_r, m1_r;
    logic           m0_rlast, m1_rlast;
    logic           s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [ARW-1:0] s_ar;
    logic [RW-1:0]  s_r;
`ifdef ARB_RD_TIMEOUT_EN
    logic           timeout_err;
`endif

    beat_t q0[$];
    beat_t q1[$];
    int    done_order[$];
    int    done_cyc[$];
    int    n_checks = 0, n_errors = 0;
    int    stray0 = 0, stray1 = 0, spurious = 0, early_ar0 = 0;
    int    cyc = 0;
    logic  watch_m1 = 1'b0;
    logic  slave_silent = 1'b0;
    int    lat0, lat1, acyc0, acyc0b, acyc1;

    ysyx_23060221_axi_rd_rr_arbiter #(
        .AW(AW), .DW(DW), .IDW(IDW), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst(rst),
`ifdef ARB_RD_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r), .s_rlast(s_rlast)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input int b);
        return 32'hDEADBEEF + {16'h0, a[15:0]} + 32'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic score(input int m, input logic [RW-1:0] r, input logic last);
        beat_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            spurious++;
            return;
        end
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("m%0d_data", m), 64'(r[RW-1:IDW+2]), 64'(e.data));
        check($sformatf("m%0d_id", m),   64'(r[IDW+1:2]),    64'(e.id));
        check($sformatf("m%0d_resp", m), 64'(r[1:0]),        64'(e.resp));
        check($sformatf("m%0d_last", m), 64'(last),          64'(e.last));
        if (e.last) begin
            done_order.push_back(m);
            done_cyc.push_back(cyc);
        end
    endtask

    // Master-side monitor: every accepted beat is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (m0_rvalid && q0.size() == 0) stray0++;
        if (m1_rvalid && q1.size() == 0) stray1++;
        if (watch_m1 && m0_arready && q1.size() != 0) early_ar0++;
        if (m0_rvalid && m0_rready) score(0, m0_r, m0_rlast);
        if (m1_rvalid && m1_rready) score(1, m1_r, m1_rlast);
    end

    // Downstream slave: accepts one AR at a time and streams len+1 beats.
    initial begin : slave
        logic           f_ar, f_r, rst_snap;
        logic [ARW-1:0] ar_snap;
        logic [AW-1:0]  sl_addr;
        logic [IDW-1:0] sl_id;
        int             sl_len, sl_beat;
        logic           sl_busy;
        sl_busy = 1'b0; sl_addr = '0; sl_id = '0; sl_len = 0; sl_beat = 0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_r = '0; s_rlast = 1'b0;
        forever begin
            @(negedge clk);
            f_ar = s_arvalid && s_arready;
            f_r = s_rvalid && s_rready;
            ar_snap = s_ar;
            rst_snap = rst;
            step();
            if (rst_snap) begin
                sl_busy = 1'b0;
            end else begin
                if (f_r) begin
                    if (sl_beat == sl_len) sl_busy = 1'b0;
                    else sl_beat++;
                end
                if (f_ar) begin
                    sl_addr = ar_snap[ARW-1:IDW+13];
                    sl_id   = ar_snap[IDW+12:13];
                    sl_len  = int'(ar_snap[12:5]);
                    sl_beat = 0;
                    sl_busy = 1'b1;
                end
            end
            s_arready = !sl_busy;
            s_rvalid  = sl_busy && !slave_silent;
            s_r       = sl_busy ? {exp_data(sl_addr, sl_beat), sl_id, 2'b00} : '0;
            s_rlast   = sl_busy && (sl_beat == sl_len);
        end
    end

    task automatic issue(input int m, input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                         input int len, input bit err, output int lat, output int acyc);
        logic [ARW-1:0] p;
        beat_t          e;
        int             n;
        logic           rdy;
        p = {addr, id, 8'(len), 3'b010, 2'b01};
        step();
        for (int b = 0; b <= len; b++) begin
            e.data = err ? '0 : exp_data(addr, b);
            e.id   = id;
            e.resp = err ? 2'b11 : 2'b00;
            e.last = (b == len);
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (m == 0) begin m0_arvalid = 1'b1; m0_ar = p; end
        else        begin m1_arvalid = 1'b1; m1_ar = p; end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (m == 0) ? m0_arready : m1_arready;
            if (rdy || n >= 200) break;
            step();
            n++;
        end
        check($sformatf("m%0d_ar_grant", m), 64'(rdy), 64'd1);
        check($sformatf("m%0d_s_ar", m), 64'(s_ar), 64'(p));
        lat  = n;
        acyc = cyc;
        step();
        if (m == 0) begin m0_arvalid = 1'b0; m0_ar = '0; end
        else        begin m1_arvalid = 1'b0; m1_ar = '0; end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
        step();
        step();
    endtask

    task automatic wait_q(input int m, input int sz);
        int n;
        n = 0;
        while (((m == 0) ? q0.size() : q1.size()) != sz && n < 200) begin
            step();
            n++;
        end
        check("wait_q", 64'((m == 0) ? q0.size() : q1.size()), 64'(sz));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({s_arvalid, s_rready, m0_arready, m1_arready,
                    m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, (|m0_r), (|m1_r), (|s_ar)});
    endfunction

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
`ifdef ARB_RD_TIMEOUT_EN
        check("reset_timeout_err", 64'(timeout_err), 64'd0);
`endif

        // Single IFU read: s_arvalid in the cycle after the request.
        issue(0, 32'h3000_0000, 4'h1, 0, 1'b0, lat0, acyc0);
        check("t1_ar_latency", 64'(lat0), 64'd1);
        wait_done();
        check("t1_done_count", 64'(done_order.size()), 64'd1);
        check("t1_m1_quiet", 64'(stray1), 64'd0);

        // Simultaneous requests after reset: m0, m1, m0.
        do_reset();
        done_order.delete();
        done_cyc.delete();
        fork
            begin
                issue(0, 32'h3000_0010, 4'h2, 1, 1'b0, lat0, acyc0);
                issue(0, 32'h3000_0020, 4'h3, 2, 1'b0, lat0, acyc0b);
            end
            issue(1, 32'h8000_0010, 4'h9, 0, 1'b0, lat1, acyc1);
        join
        wait_done();
        check("t2_done_count", 64'(done_order.size()), 64'd3);
        check("t2_first",  64'(done_order[0]), 64'd0);
        check("t2_second", 64'(done_order[1]), 64'd1);
        check("t2_third",  64'(done_order[2]), 64'd0);
        check("t2_m1_grant_cycle", 64'(acyc1), 64'(done_cyc[0] + 2));
        check("t2_m0_regrant_cycle", 64'(acyc0b), 64'(done_cyc[1] + 2));

        // LSU burst of 4 with an IFU request raised after the first beat.
        done_order.delete();
        done_cyc.delete();
        watch_m1 = 1'b1;
        fork
            issue(1, 32'h8000_0100, 4'h4, 3, 1'b0, lat1, acyc1);
            begin
                wait_q(1, 3);
                issue(0, 32'h3000_0040, 4'h5, 0, 1'b0, lat0, acyc0);
            end
        join
        wait_done();
        watch_m1 = 1'b0;
        check("t3_early_m0_arready", 64'(early_ar0), 64'd0);
        check("t3_first",  64'(done_order[0]), 64'd1);
        check("t3_second", 64'(done_order[1]), 64'd0);
        check("t3_m0_grant_cycle", 64'(acyc0), 64'(done_cyc[0] + 2));

        // Backpressure: m1_rready low for 5 cycles while the slave holds a beat.
        fork
            issue(1, 32'h8000_0200, 4'h6, 3, 1'b0, lat1, acyc1);
            begin
                logic [DW-1:0] held;
                wait_q(1, 3);
                m1_rready = 1'b0;
                held = q1[0].data;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("t4_s_rready_low", 64'(s_rready), 64'd0);
                    check("t4_rvalid_held", 64'(m1_rvalid), 64'd1);
                    check("t4_data_held", 64'(m1_r[RW-1:IDW+2]), 64'(held));
                    step();
                end
                m1_rready = 1'b1;
            end
        join
        wait_done();

        // Reset in DATA after beat 1 of 4, then a fresh IFU read.
        fork
            issue(0, 32'h3000_0300, 4'h7, 3, 1'b0, lat0, acyc0);
            begin
                wait_q(0, 3);
                rst = 1'b1;
                step();
                rst = 1'b0;
                @(negedge clk);
                check("t5_outputs_after_rst", out_vec(), 64'd0);
            end
        join
        q0.delete();
        done_order.delete();
        issue(0, 32'h3000_0400, 4'h8, 1, 1'b0, lat0, acyc0);
        check("t5_ar_latency", 64'(lat0), 64'd1);
        wait_done();
        check("t5_done_count", 64'(done_order.size()), 64'd1);

`ifdef ARB_RD_TIMEOUT_EN
        // Silent slave: DECERR beat exactly 8 cycles after the AR handshake.
        begin
            int n;
            check("t6_err_before", 64'(timeout_err), 64'd0);
            slave_silent = 1'b1;
            issue(0, 32'h3000_0500, 4'h5, 0, 1'b1, lat0, acyc0);
            n = 0;
            forever begin
                @(negedge clk);
                if (m0_rvalid || n >= 50) break;
                step();
                n++;
            end
            check("t6_timeout_cycles", 64'(n), 64'd8);
            check("t6_rlast", 64'(m0_rlast), 64'd1);
            check("t6_s_rready", 64'(s_rready), 64'd0);
            check("t6_timeout_err", 64'(timeout_err), 64'd1);
            wait_done();
            check("t6_err_sticky", 64'(timeout_err), 64'd1);
            do_reset();
            slave_silent = 1'b0;
            @(negedge clk);
            check("t6_err_cleared", 64'(timeout_err), 64'd0);
        end
`endif

        check("stray_m0_rvalid", 64'(stray0), 64'd0);
        check("stray_m1_rvalid", 64'(stray1), 64'd0);
        check("spurious_beats", 64'(spurious), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060221_axi_rd_rr_arbiter.md
Name: ysyx_23060221_axi_rd_rr_arbiter

Overview:
- Two-master AXI4 read-channel arbiter between IFU (m0) and LSU (m1) and a single downstream read slave (xbar/io_master side).
- Round-robin grant with per-transaction locking: the grant is held from AR acceptance through the last R beat.
- Replaces the combinational, priority-only read mux; the write channels are out of scope and stay direct LSU-to-slave.
- Registered FSM, so bursts are never interleaved and a fetch can never be dropped mid-burst.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- IDW, 4, ID width.
- TIMEOUT_CYCLES, 255, R-phase watchdog limit; used only with the optional feature. Legal range 1..1023.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m0_arvalid  in  1  IFU AR valid.
- m0_arready  out  1  IFU AR ready.
- m0_ar  in  AW+IDW+13  IFU AR payload {addr, id, len[7:0], size[2:0], burst[1:0]}.
- m0_rvalid  out  1  IFU R valid.
- m0_rready  in  1  IFU R ready.
- m0_r  out  DW+IDW+2  IFU R payload {data, id, resp[1:0]}.
- m0_rlast  out  1  IFU R last.
- m1_arvalid, m1_arready, m1_ar, m1_rvalid, m1_rready, m1_r, m1_rlast: LSU, same directions and widths as m0.
- s_arvalid  out  1  slave AR valid.
- s_arready  in  1  slave AR ready.
- s_ar  out  AW+IDW+13  slave AR payload.
- s_rvalid  in  1  slave R valid.
- s_rready  out  1  slave R ready.
- s_r  in  DW+IDW+2  slave R payload.
- s_rlast  in  1  slave R last.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- FSM states:
  - IDLE: no grant; all valid and ready outputs are 0.
  - ADDR: the granted master's arvalid/ar are forwarded combinationally to s_arvalid/s_ar, and s_arready is returned to that master only.
  - DATA: s_r, s_rvalid and s_rlast go to the granted master; that master's rready drives s_rready.
- Non-granted master: sees arready=0, rvalid=0, rlast=0 and r=0 at all times.
- Grant decision, made in IDLE:
  - If only one arvalid is high, that master is granted.
  - If both are high, the master other than last_grant is granted.
  - The grant is registered, giving IDLE->ADDR on the next edge. This is 1 cycle of arbitration latency; the earliest s_arvalid is the cycle after the request.
- ADDR->DATA on s_arvalid & s_arready.
- If the granted master drops arvalid in ADDR (protocol violation), the FSM returns to IDLE without a handshake and last_grant is unchanged.
- DATA->IDLE on s_rvalid & s_rready & s_rlast; last_grant is set to the master just served.
- Beats with rlast=0 keep DATA for any arlen.
- Back-to-back transactions: at least one IDLE cycle separates them. A request arriving in the same cycle as the final beat is arbitrated in the following IDLE cycle.
- s_rvalid in IDLE or ADDR is ignored (s_rready=0).
- Reset values: state=IDLE, last_grant=m1 (so m0 wins the first tie), all outputs 0.
- Reset mid-transaction: the FSM returns to IDLE at the sampling edge. Outputs drop to 0 in that cycle; no completion is generated for the aborted burst.
- No buffering: payloads pass through combinationally within the granted path, so the arbiter adds zero data-path latency after the grant.

Optional Feature:
- Macro: ARB_RD_TIMEOUT_EN.
- When defined:
  - A 10-bit counter clears on entry to DATA and on every R handshake, and increments each other DATA cycle.
  - When it reaches TIMEOUT_CYCLES, the arbiter drives the granted master for one cycle with rvalid=1, rlast=1, resp=2'b11 (DECERR), data=0, id=the AR id latched at the AR handshake. The slave is not consulted that cycle: s_rready=0.
  - The arbiter waits for the master's rready, then returns to IDLE.
  - Sticky output port timeout_err (out, 1) sets on a timeout and clears only on rst.
- When undefined: no counter and no timeout_err port; DATA waits indefinitely.

Test Plan:
- Single IFU read: m0_arvalid with addr 0x30000000, len=0. Expect s_arvalid in cycle 2. Slave returns data 0xDEADBEEF, rlast=1; expect m0 sees it and m1_rvalid stays 0 throughout.
- Simultaneous m0/m1 requests after reset: m0 is served first. m1 is granted the cycle after m0's rlast handshake plus one IDLE cycle, and then m0 is re-requested; expect order m0, m1, m0.
- LSU burst len=3: the 4 beats all reach m1 only. An m0 request raised mid-burst must not see arready until after beat 4's rlast.
- Backpressure: m1_rready low for 5 cycles with s_rvalid high. Expect s_rready low, data held, and no beat lost or duplicated.
- rst asserted in DATA after beat 1 of 4: all outputs are 0 the next cycle. A fresh m0 request then completes normally.
- ARB_RD_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a silent slave: exactly 8 cycles after the AR handshake, m0 gets resp=2'b11, rlast=1 with the request's id, and timeout_err=1.
